// File: rtl/orange_pkg.sv
// Shared types and the direction decision for the orange-detection frame sequencer.
package orange_pkg;

  typedef enum logic [2:0] {
    DIR_NONE   = 3'b000,
    DIR_LEFT   = 3'b001,
    DIR_RIGHT  = 3'b010,
    DIR_CENTER = 3'b011
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_EVAL   = 2'd3
  } seq_state_t;

  // First matching rule wins; a center tie beats both sides.
  function automatic dir_t pick_dir(input logic [31:0] left_cnt, input logic [31:0] center_cnt,
                                    input logic [31:0] right_cnt, input logic [31:0] total_cnt);
    dir_t d;
    if (total_cnt == 32'd0)                                    d = DIR_NONE;
    else if (center_cnt >= left_cnt && center_cnt >= right_cnt) d = DIR_CENTER;
    else if (right_cnt > left_cnt)                             d = DIR_RIGHT;
    else                                                       d = DIR_LEFT;
    return d;
  endfunction

endpackage

// File: rtl/orange_frame_sequencer_if.sv
// Per-frame result handshake from the frame sequencer to the motion logic.
interface orange_frame_sequencer_if #(parameter int CNT_W = 17);
  import orange_pkg::*;

  logic             res_valid;
  logic             res_ready;
  dir_t             res_direction;
  logic             res_detected;
  logic [CNT_W-1:0] res_count;

  modport master (output res_valid, res_direction, res_detected, res_count, input res_ready);
  modport slave  (input res_valid, res_direction, res_detected, res_count, output res_ready);
endinterface

// File: rtl/orange_zone_counter.sv
// Left/center/right/total orange-pixel accumulators; zone chosen from the current column.
module orange_zone_counter
  import orange_pkg::*;
#(
  parameter int LEFT_END    = 100,
  parameter int RIGHT_START = 220,
  parameter int CNT_W       = 17,
  parameter int COL_W       = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             count_en,
  input  logic [COL_W-1:0] col,
  output logic [CNT_W-1:0] left_cnt,
  output logic [CNT_W-1:0] center_cnt,
  output logic [CNT_W-1:0] right_cnt,
  output logic [CNT_W-1:0] total_cnt
);

  localparam logic [COL_W-1:0] L_END   = COL_W'(LEFT_END);
  localparam logic [COL_W-1:0] R_START = COL_W'(RIGHT_START);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      left_cnt   <= '0;
      center_cnt <= '0;
      right_cnt  <= '0;
      total_cnt  <= '0;
    end else if (count_en) begin
      total_cnt <= total_cnt + ONE;
      if (col < L_END)        left_cnt   <= left_cnt + ONE;
      else if (col >= R_START) right_cnt <= right_cnt + ONE;
      else                    center_cnt <= center_cnt + ONE;
    end
  end

endmodule

// File: rtl/orange_frame_sequencer.sv
// Frame sequencer: follows VSYNC/HREF, accumulates orange pixels per zone over one frame,
// and offers one direction/count result per frame over a valid/ready handshake.
//
//   state     | meaning
//   ST_IDLE   | disabled; position and counters held clear
//   ST_SYNC   | enabled, waiting for a VSYNC rise so no frame is joined mid-way
//   ST_ACTIVE | tracking col/row and accumulating orange pixels
//   ST_EVAL   | one cycle: load result register, clear accumulators
module orange_frame_sequencer
  import orange_pkg::*;
#(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int LEFT_END    = 100,
  parameter int RIGHT_START = 220,
  parameter int THRESH_DIV  = 4,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       vsync,
  input  logic       href,
  input  logic       pix_valid,
  input  logic       is_orange,
  output logic       frame_busy,
  output logic [7:0] drop_count,
  orange_frame_sequencer_if.master res
);

  localparam int COL_W = $clog2(H_ACTIVE + 1);
  localparam int ROW_W = $clog2(V_ACTIVE + 1);
  localparam logic [COL_W-1:0] COL_LIM  = COL_W'(H_ACTIVE);
  localparam logic [ROW_W-1:0] ROW_LIM  = ROW_W'(V_ACTIVE);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [CNT_W-1:0] THRESH   = CNT_W'(H_ACTIVE * V_ACTIVE / THRESH_DIV);

  seq_state_t       state, state_nxt;
  logic             vsync_q, href_q;
  logic             vsync_rise, href_fall, frame_end;
  logic             clear, count_en, load;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [CNT_W-1:0] left_cnt, center_cnt, right_cnt, total_cnt;

  assign vsync_rise = vsync && !vsync_q;
  assign href_fall  = !href && href_q;
  assign frame_end  = href_fall && (row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   state_nxt = ST_SYNC;
        ST_SYNC:   if (vsync_rise) state_nxt = ST_ACTIVE;
        ST_ACTIVE: if (frame_end) state_nxt = ST_EVAL;
        ST_EVAL:   state_nxt = ST_ACTIVE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // A VSYNC rise coinciding with the last HREF fall still lets that frame finish.
  always_comb begin
    frame_busy = (state == ST_ACTIVE);
    load       = enable && (state == ST_EVAL);
    clear      = !enable || (state != ST_ACTIVE) || (vsync_rise && !frame_end);
    count_en   = enable && (state == ST_ACTIVE) && href && pix_valid && is_orange
                 && (col < COL_LIM) && (row < ROW_LIM);
  end

  // Position saturates so runaway lines never wrap back into the active window.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (href_fall) begin
      col <= '0;
      if (row != '1) row <= row + ROW_ONE;
    end else if (href && pix_valid && (col != '1)) begin
      col <= col + COL_ONE;
    end
  end

  orange_zone_counter #(
    .LEFT_END   (LEFT_END),
    .RIGHT_START(RIGHT_START),
    .CNT_W      (CNT_W),
    .COL_W      (COL_W)
  ) u_zone (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .count_en  (count_en),
    .col       (col),
    .left_cnt  (left_cnt),
    .center_cnt(center_cnt),
    .right_cnt (right_cnt),
    .total_cnt (total_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      res.res_valid     <= 1'b0;
      res.res_direction <= DIR_NONE;
      res.res_detected  <= 1'b0;
      res.res_count     <= '0;
      drop_count        <= '0;
    end else if (load) begin
      res.res_valid     <= 1'b1;
      res.res_direction <= pick_dir(32'(left_cnt), 32'(center_cnt), 32'(right_cnt), 32'(total_cnt));
      res.res_detected  <= (total_cnt > THRESH);
      res.res_count     <= total_cnt;
      if (res.res_valid && !res.res_ready && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
    end else if (res.res_valid && res.res_ready) begin
      res.res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_orange_frame_sequencer.sv
// Directed + randomized bench for the orange frame sequencer on a scaled-down 32x24 frame.
module tb_orange_frame_sequencer;
  import orange_pkg::*;

  localparam int H_A = 32;
  localparam int V_A = 24;
  localparam int L_E = 10;
  localparam int R_S = 22;
  localparam int T_D = 4;
  localparam int C_W = 10;

  logic       clk = 1'b0;
  logic       reset, enable, vsync, href, pix_valid, is_orange;
  logic       frame_busy;
  logic [7:0] drop_count;

  orange_frame_sequencer_if #(.CNT_W(C_W)) res_if ();

  orange_frame_sequencer #(
    .H_ACTIVE(H_A), .V_ACTIVE(V_A), .LEFT_END(L_E), .RIGHT_START(R_S),
    .THRESH_DIV(T_D), .CNT_W(C_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .vsync(vsync), .href(href),
    .pix_valid(pix_valid), .is_orange(is_orange), .frame_busy(frame_busy),
    .drop_count(drop_count), .res(res_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit omap [V_A][H_A];
  int exp_cnt, exp_dir, exp_det;
  int saved_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: count the bitmap by zone and apply the direction/threshold rules directly.
  task automatic model();
    int l, c, r, t;
    l = 0; c = 0; r = 0;
    for (int y = 0; y < V_A; y++)
      for (int x = 0; x < H_A; x++)
        if (omap[y][x]) begin
          if (x < L_E) l++;
          else if (x >= R_S) r++;
          else c++;
        end
    t = l + c + r;
    exp_cnt = t;
    exp_det = (t > (H_A * V_A) / T_D) ? 1 : 0;
    if (t == 0)                 exp_dir = 0;
    else if (c >= l && c >= r)  exp_dir = 3;
    else if (r > l)             exp_dir = 2;
    else                        exp_dir = 1;
  endtask

  task automatic fill_clear();
    for (int y = 0; y < V_A; y++)
      for (int x = 0; x < H_A; x++) omap[y][x] = 1'b0;
  endtask

  task automatic fill_random(input int density);
    for (int y = 0; y < V_A; y++)
      for (int x = 0; x < H_A; x++) omap[y][x] = ($urandom_range(99) < density);
  endtask

  // Leaves href low after the last line without advancing the clock.
  task automatic send_frame(input int nrows, input bit gaps);
    vsync = 1'b1; tick(2);
    vsync = 1'b0; tick(2);
    for (int y = 0; y < nrows; y++) begin
      href = 1'b1;
      for (int x = 0; x < H_A; x++) begin
        if (gaps && $urandom_range(3) == 0) begin
          pix_valid = 1'b0;
          is_orange = 1'($urandom_range(1));
          tick(1);
        end
        pix_valid = 1'b1;
        is_orange = omap[y][x];
        tick(1);
      end
      if (gaps) begin
        pix_valid = 1'b1;
        is_orange = 1'b1;
        tick(2);
      end
      href = 1'b0; pix_valid = 1'b0; is_orange = 1'b0;
      if (y != nrows - 1) tick(3);
    end
  endtask

  task automatic chk_result(input string tag);
    chk({tag, "_valid"}, res_if.res_valid, 1);
    chk({tag, "_dir"},   res_if.res_direction, exp_dir);
    chk({tag, "_count"}, res_if.res_count, exp_cnt);
    chk({tag, "_det"},   res_if.res_detected, exp_det);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; vsync = 1'b0; href = 1'b0;
    pix_valid = 1'b0; is_orange = 1'b0; res_if.res_ready = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_busy",  frame_busy, 0);
    chk("rst_valid", res_if.res_valid, 0);
    chk("rst_dir",   res_if.res_direction, 0);
    chk("rst_count", res_if.res_count, 0);
    chk("rst_det",   res_if.res_detected, 0);
    chk("rst_drop",  drop_count, 0);

    enable = 1'b1;
    tick(2);
    for (int k = 0; k < 3; k++) begin
      href = 1'b1; pix_valid = 1'b1; is_orange = 1'b1;
      tick(5);
      chk("presync_busy", frame_busy, 0);
      href = 1'b0; pix_valid = 1'b0; is_orange = 1'b0;
      tick(2);
    end
    vsync = 1'b1;
    tick(1);
    chk("vsync_busy", frame_busy, 1);
    vsync = 1'b0;
    tick(2);

    res_if.res_ready = 1'b1;
    for (int y = 0; y < V_A; y++)
      for (int x = 0; x < H_A; x++) omap[y][x] = (x < L_E);
    model();
    send_frame(V_A, 1'b0);
    tick(1);
    chk("left_t1_valid", res_if.res_valid, 0);
    tick(1);
    chk_result("left");
    tick(1);
    chk("left_pulse_end", res_if.res_valid, 0);
    chk("left_drop", drop_count, 0);

    fill_clear();
    for (int x = 22; x < 27; x++) omap[0][x] = 1'b1;
    for (int x = 12; x < 17; x++) omap[3][x] = 1'b1;
    model();
    send_frame(V_A, 1'b1);
    tick(2);
    chk_result("tie");
    tick(1);

    fill_clear();
    for (int y = 0; y < 3; y++)
      for (int x = R_S; x < H_A; x++) omap[y][x] = 1'b1;
    for (int x = 0; x < 5; x++) omap[5][x] = 1'b1;
    model();
    send_frame(V_A, 1'b1);
    tick(2);
    chk_result("right");
    tick(1);

    fill_clear();
    model();
    send_frame(V_A, 1'b1);
    tick(2);
    chk_result("empty");
    tick(1);

    for (int f = 0; f < 3; f++) begin
      fill_random($urandom_range(5, 60));
      model();
      send_frame(V_A, 1'b1);
      tick(2);
      chk_result("rand");
      tick(1);
    end

    res_if.res_ready = 1'b0;
    fill_clear();
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < L_E; x++) omap[y][x] = 1'b1;
    model();
    saved_cnt = exp_cnt;
    send_frame(V_A, 1'b0);
    tick(2);
    chk_result("dropA");
    tick(5);
    chk("dropA_hold_valid", res_if.res_valid, 1);
    chk("dropA_hold_count", res_if.res_count, saved_cnt);
    fill_random(40);
    model();
    send_frame(V_A, 1'b1);
    tick(2);
    chk_result("dropB");
    chk("dropB_drop", drop_count, 1);
    res_if.res_ready = 1'b1;
    tick(1);
    chk("dropB_xfer_valid", res_if.res_valid, 0);
    chk("dropB_xfer_drop", drop_count, 1);

    for (int y = 0; y < V_A; y++)
      for (int x = 0; x < H_A; x++) omap[y][x] = 1'b1;
    send_frame(V_A / 2, 1'b0);
    tick(3);
    fill_random(30);
    model();
    send_frame(V_A, 1'b1);
    tick(1);
    chk("abort_no_result", res_if.res_valid, 0);
    tick(1);
    chk_result("abort_next");
    chk("abort_drop", drop_count, 1);
    tick(1);

    res_if.res_ready = 1'b0;
    for (int y = 0; y < V_A; y++)
      for (int x = 0; x < H_A; x++) omap[y][x] = (x < L_E);
    model();
    send_frame(V_A, 1'b0);
    tick(2);
    chk_result("prereset");
    send_frame(5, 1'b0);
    reset = 1'b1;
    tick(1);
    chk("mrst_busy",  frame_busy, 0);
    chk("mrst_valid", res_if.res_valid, 0);
    chk("mrst_dir",   res_if.res_direction, 0);
    chk("mrst_count", res_if.res_count, 0);
    chk("mrst_det",   res_if.res_detected, 0);
    chk("mrst_drop",  drop_count, 0);
    chk("mrst_state", dut.state, ST_IDLE);
    reset = 1'b0;
    href = 1'b1; pix_valid = 1'b1;
    tick(4);
    chk("post_rst_busy", frame_busy, 0);
    href = 1'b0; pix_valid = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
